// File: rtl/rice_core_pkg.sv
// ---------------------------------------------------------------------------
// rice_core_pkg
// Shared definitions for the RICE core trap controller: machine interrupt
// cause codes, trap FSM state encoding, mtvec mode encoding and a small
// helper that decides whether an mtvec mode selects vectored dispatch.
// No ports; imported by rice_core_trap_ctrl and rice_core_trap_prio_enc.
// ---------------------------------------------------------------------------
package rice_core_pkg;

    // Width of the internal cause code. It covers the local interrupt causes
    // (up to 31) and exception vectors up to 256 bits wide.
    localparam int CODE_W = 8;

    // Standard machine-level interrupt cause codes and mip bit positions.
    localparam int IRQ_MSI_CODE   = 3;
    localparam int IRQ_MTI_CODE   = 7;
    localparam int IRQ_MEI_CODE   = 11;
    // Local interrupt i is reported as cause LOCAL_IRQ_BASE + i.
    localparam int LOCAL_IRQ_BASE = 16;

    typedef enum logic [1:0] {
        TRAP_IDLE   = 2'd0,
        TRAP_REQ    = 2'd1,
        TRAP_COMMIT = 2'd2
    } trap_state_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1,
        MTVEC_RSVD2    = 2'd2,
        MTVEC_RSVD3    = 2'd3
    } mtvec_mode_e;

    // Reserved modes 2 and 3 fall back to direct dispatch.
    function automatic logic is_vectored(input logic [1:0] mode);
        return mtvec_mode_e'(mode) == MTVEC_VECTORED;
    endfunction

endpackage

// File: rtl/rice_core_trap_prio_enc.sv
// ---------------------------------------------------------------------------
// rice_core_trap_prio_enc
// Picks the single trap cause to take from the enabled pending interrupts and
// the raw exception flags. Exceptions beat interrupts and the lowest set
// exception bit wins. Interrupt order is MEI > MSI > MTI > local, with the
// lowest local index first.
// Ports:
//   i_pending   - pending interrupts already masked by mie and mstatus.MIE
//   i_exception - exception flags, bit index = cause code
//   o_valid     - a trap cause is present
//   o_interrupt - the chosen cause is an interrupt
//   o_code      - cause code of the chosen trap
// ---------------------------------------------------------------------------
module rice_core_trap_prio_enc
    import rice_core_pkg::*;
#(
    parameter int MIP_W     = 24,
    parameter int EXC_WIDTH = 16
) (
    input  logic [MIP_W-1:0]     i_pending,
    input  logic [EXC_WIDTH-1:0] i_exception,
    output logic                 o_valid,
    output logic                 o_interrupt,
    output logic [CODE_W-1:0]    o_code
);

    // Reserved mip positions never carry an interrupt.
    logic unused_pending;
    assign unused_pending = ^{i_pending[15:12], i_pending[10:8],
                              i_pending[6:4], i_pending[2:0]};

    // Candidates are visited from lowest to highest priority, so every later
    // hit overwrites an earlier one and the last write is the winner.
    always_comb begin
        o_valid     = 1'b0;
        o_interrupt = 1'b0;
        o_code      = '0;
        for (int i = MIP_W - 1; i >= LOCAL_IRQ_BASE; i--) begin
            if (i_pending[i]) begin
                o_valid     = 1'b1;
                o_interrupt = 1'b1;
                o_code      = CODE_W'(i);
            end
        end
        if (i_pending[IRQ_MTI_CODE]) begin
            o_valid     = 1'b1;
            o_interrupt = 1'b1;
            o_code      = CODE_W'(IRQ_MTI_CODE);
        end
        if (i_pending[IRQ_MSI_CODE]) begin
            o_valid     = 1'b1;
            o_interrupt = 1'b1;
            o_code      = CODE_W'(IRQ_MSI_CODE);
        end
        if (i_pending[IRQ_MEI_CODE]) begin
            o_valid     = 1'b1;
            o_interrupt = 1'b1;
            o_code      = CODE_W'(IRQ_MEI_CODE);
        end
        for (int i = EXC_WIDTH - 1; i >= 0; i--) begin
            if (i_exception[i]) begin
                o_valid     = 1'b1;
                o_interrupt = 1'b0;
                o_code      = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/rice_core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// rice_core_trap_ctrl
// Machine-mode trap controller. It collects interrupt lines into mip, picks
// the highest priority exception or enabled interrupt, latches cause, mepc
// and handler address, then runs a request/ack handshake with the pipeline
// and pulses o_csr_update once the trap is accepted.
// Ports:
//   i_clk, i_rst_n      - clock, asynchronous active-low reset
//   i_enable            - core enable; low aborts any trap in flight
//   i_exception, i_pc   - exception flags and PC of the affected instruction
//   i_irq_msi/mti/mei   - level-sensitive machine software/timer/external irq
//   i_irq_local         - level-sensitive platform-local irqs (cause 16+i)
//   i_mstatus_mie,i_mie - global and per-interrupt enables
//   i_mtvec_base/mode   - trap vector base (word aligned) and dispatch mode
//   o_trap_req,i_trap_ack - trap handshake with the pipeline
//   o_trap_pc, o_mcause, o_mepc - handler address and CSR values for the trap
//   o_csr_update        - one-cycle pulse that commits mepc/mcause/mstatus
//   o_mip               - pending interrupt bits
// Configuration macro: RICE_CORE_IRQ_SYNC_EN adds a 2-flop synchroniser on
// every interrupt input ahead of mip; without it mip is a single register.
// ---------------------------------------------------------------------------
module rice_core_trap_ctrl
    import rice_core_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int IRQ_CHANNELS = 8,
    parameter int EXC_WIDTH    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic [EXC_WIDTH-1:0]       i_exception,
    input  logic [XLEN-1:0]            i_pc,
    input  logic                       i_irq_msi,
    input  logic                       i_irq_mti,
    input  logic                       i_irq_mei,
    input  logic [IRQ_CHANNELS-1:0]    i_irq_local,
    input  logic                       i_mstatus_mie,
    input  logic [16+IRQ_CHANNELS-1:0] i_mie,
    input  logic [XLEN-3:0]            i_mtvec_base,
    input  logic [1:0]                 i_mtvec_mode,
    output logic                       o_trap_req,
    input  logic                       i_trap_ack,
    output logic [XLEN-1:0]            o_trap_pc,
    output logic [XLEN-1:0]            o_mcause,
    output logic [XLEN-1:0]            o_mepc,
    output logic                       o_csr_update,
    output logic [16+IRQ_CHANNELS-1:0] o_mip
);

    localparam int MIP_W = LOCAL_IRQ_BASE + IRQ_CHANNELS;

    logic [MIP_W-1:0]  mip_raw;
    logic [MIP_W-1:0]  mip_d, mip_q;
    logic [MIP_W-1:0]  pending_masked;

    trap_state_e       state_d, state_q;
    logic [XLEN-1:0]   trap_pc_d, trap_pc_q;
    logic [XLEN-1:0]   mcause_d, mcause_q;
    logic [XLEN-1:0]   mepc_d, mepc_q;

    logic              enc_valid;
    logic              enc_interrupt;
    logic [CODE_W-1:0] enc_code;
    logic [XLEN-1:0]   vec_base;
    logic [XLEN-1:0]   trap_pc_new;
    logic [XLEN-1:0]   mcause_new;

    // Place every interrupt line at its architectural mip bit position.
    always_comb begin
        mip_raw               = '0;
        mip_raw[IRQ_MSI_CODE] = i_irq_msi;
        mip_raw[IRQ_MTI_CODE] = i_irq_mti;
        mip_raw[IRQ_MEI_CODE] = i_irq_mei;
        for (int i = 0; i < IRQ_CHANNELS; i++) begin
            mip_raw[LOCAL_IRQ_BASE + i] = i_irq_local[i];
        end
    end

`ifdef RICE_CORE_IRQ_SYNC_EN
    logic [MIP_W-1:0] sync_d, sync_q;

    // First synchroniser stage; mip_q acts as the second stage.
    always_comb begin
        sync_d = mip_raw;
        mip_d  = sync_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    always_comb begin
        mip_d = mip_raw;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mip_q <= '0;
        end else begin
            mip_q <= mip_d;
        end
    end

    assign o_mip          = mip_q;
    assign pending_masked = mip_q & i_mie & {MIP_W{i_mstatus_mie}};

    rice_core_trap_prio_enc #(
        .MIP_W     (MIP_W),
        .EXC_WIDTH (EXC_WIDTH)
    ) u_prio_enc (
        .i_pending   (pending_masked),
        .i_exception (i_exception),
        .o_valid     (enc_valid),
        .o_interrupt (enc_interrupt),
        .o_code      (enc_code)
    );

    // Handler address and mcause for the cause currently selected. Only
    // interrupts in vectored mode get the 4*code offset; the add wraps.
    always_comb begin
        vec_base = {i_mtvec_base, 2'b00};
        if (enc_interrupt && is_vectored(i_mtvec_mode)) begin
            trap_pc_new = vec_base + (XLEN'(enc_code) << 2);
        end else begin
            trap_pc_new = vec_base;
        end
        mcause_new = {enc_interrupt, (XLEN-1)'(enc_code)};
    end

    // State register together with the trap record latched on entry to REQ.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= TRAP_IDLE;
            trap_pc_q <= '0;
            mcause_q  <= '0;
            mepc_q    <= '0;
        end else begin
            state_q   <= state_d;
            trap_pc_q <= trap_pc_d;
            mcause_q  <= mcause_d;
            mepc_q    <= mepc_d;
        end
    end

    // Next-state logic. The trap record is only captured in IDLE, so it stays
    // frozen while the pipeline has not yet acknowledged the request.
    always_comb begin
        state_d   = state_q;
        trap_pc_d = trap_pc_q;
        mcause_d  = mcause_q;
        mepc_d    = mepc_q;
        case (state_q)
            TRAP_IDLE: begin
                if (enc_valid && i_enable) begin
                    state_d   = TRAP_REQ;
                    trap_pc_d = trap_pc_new;
                    mcause_d  = mcause_new;
                    mepc_d    = i_pc;
                end
            end
            TRAP_REQ: begin
                if (i_trap_ack) begin
                    state_d = TRAP_COMMIT;
                end
            end
            TRAP_COMMIT: begin
                state_d = TRAP_IDLE;
            end
            default: begin
                state_d = TRAP_IDLE;
            end
        endcase
        if (!i_enable) begin
            state_d = TRAP_IDLE;
        end
    end

    // Outputs. A disabled core sees neither the request nor the commit pulse,
    // even in the cycle before the FSM returns to IDLE.
    always_comb begin
        o_trap_req   = (state_q == TRAP_REQ) && i_enable;
        o_csr_update = (state_q == TRAP_COMMIT) && i_enable;
        o_trap_pc    = trap_pc_q;
        o_mcause     = mcause_q;
        o_mepc       = mepc_q;
    end

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rice_core_trap_ctrl
// Self-checking bench for rice_core_trap_ctrl in its default configuration
// (XLEN=32, 8 local irqs, 16 exception bits, no irq synchroniser). Expected
// trap records are pushed to a scoreboard queue when a trap is provoked and
// popped when the DUT raises o_trap_req.
// ---------------------------------------------------------------------------
module tb_rice_core_trap_ctrl;

    typedef struct {
        logic [31:0] mcause;
        logic [31:0] trap_pc;
        logic [31:0] mepc;
    } exp_t;

    typedef struct {
        logic        msi;
        logic        mti;
        logic        mei;
        logic [7:0]  loc;
        logic [1:0]  mode;
        logic [29:0] base;
        logic [31:0] pc;
    } irq_case_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [15:0] i_exception;
    logic [31:0] i_pc;
    logic        i_irq_msi;
    logic        i_irq_mti;
    logic        i_irq_mei;
    logic [7:0]  i_irq_local;
    logic        i_mstatus_mie;
    logic [23:0] i_mie;
    logic [29:0] i_mtvec_base;
    logic [1:0]  i_mtvec_mode;
    logic        o_trap_req;
    logic        i_trap_ack;
    logic [31:0] o_trap_pc;
    logic [31:0] o_mcause;
    logic [31:0] o_mepc;
    logic        o_csr_update;
    logic [23:0] o_mip;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   csr_pulses = 0;

    rice_core_trap_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_exception   (i_exception),
        .i_pc          (i_pc),
        .i_irq_msi     (i_irq_msi),
        .i_irq_mti     (i_irq_mti),
        .i_irq_mei     (i_irq_mei),
        .i_irq_local   (i_irq_local),
        .i_mstatus_mie (i_mstatus_mie),
        .i_mie         (i_mie),
        .i_mtvec_base  (i_mtvec_base),
        .i_mtvec_mode  (i_mtvec_mode),
        .o_trap_req    (o_trap_req),
        .i_trap_ack    (i_trap_ack),
        .o_trap_pc     (o_trap_pc),
        .o_mcause      (o_mcause),
        .o_mepc        (o_mepc),
        .o_csr_update  (o_csr_update),
        .o_mip         (o_mip)
    );

    always #5 i_clk = ~i_clk;

    // Count every cycle in which the CSR commit pulse is high.
    always @(negedge i_clk) begin
        if (o_csr_update === 1'b1) csr_pulses++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t model_trap(input bit is_irq, input int code, input logic [29:0] base,
                                        input logic [1:0] mode, input logic [31:0] pc);
        exp_t e;
        e.mcause  = {is_irq, 31'(code)};
        e.trap_pc = {base, 2'b00};
        if (is_irq && mode == 2'd1) e.trap_pc = e.trap_pc + 32'(code) * 32'd4;
        e.mepc = pc;
        return e;
    endfunction

    function automatic int model_irq_code(input logic [23:0] pend);
        if (pend[11]) return 11;
        if (pend[3]) return 3;
        if (pend[7]) return 7;
        for (int i = 16; i < 24; i++) if (pend[i]) return i;
        return -1;
    endfunction

    function automatic int model_exc_code(input logic [15:0] exc);
        for (int i = 0; i < 16; i++) if (exc[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_exception   = '0;
        i_pc          = '0;
        i_irq_msi     = 1'b0;
        i_irq_mti     = 1'b0;
        i_irq_mei     = 1'b0;
        i_irq_local   = '0;
        i_mstatus_mie = 1'b0;
        i_mie         = '0;
        i_mtvec_base  = 30'h80;
        i_mtvec_mode  = 2'd0;
        i_trap_ack    = 1'b0;
    endtask

    task automatic pop_exp(output exp_t e);
        e = '{default: '0};
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic wait_req(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (o_trap_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (o_trap_req === 1'b1) seen = 1'b1;
    endtask

    task automatic ack_trap();
        i_trap_ack = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        clear_inputs();
        i_irq_mei   = 1'b1;
        i_exception = 16'h0001;
        repeat (3) tick();
        checks++;
        if ({o_trap_req, o_csr_update, o_trap_pc, o_mcause, o_mepc, o_mip} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got req=%0b csr=%0b pc=%h cause=%h epc=%h mip=%h exp=all zero",
                     o_trap_req, o_csr_update, o_trap_pc, o_mcause, o_mepc, o_mip);
        end
        clear_inputs();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exception();
        exp_t e;
        clear_inputs();
        i_mtvec_base = 30'h80;
        i_pc         = 32'h100;
        i_exception  = 16'h0004;
        sb.push_back(model_trap(0, 2, 30'h80, 2'd0, 32'h100));
        tick();
        checks++;
        if (o_trap_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL exc_latency got=%0b exp=1", o_trap_req);
        end
        i_exception = '0;
        i_pc        = 32'hDEAD;
        pop_exp(e);
        checks++;
        if (o_mcause !== e.mcause) begin
            failures++;
            $display("[TB] FAIL exc_mcause got=%h exp=%h", o_mcause, e.mcause);
        end
        checks++;
        if (o_trap_pc !== e.trap_pc) begin
            failures++;
            $display("[TB] FAIL exc_trap_pc got=%h exp=%h", o_trap_pc, e.trap_pc);
        end
        checks++;
        if (o_mepc !== e.mepc) begin
            failures++;
            $display("[TB] FAIL exc_mepc got=%h exp=%h", o_mepc, e.mepc);
        end
        i_trap_ack = 1'b1;
        tick();
        checks++;
        if ({o_csr_update, o_trap_req} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL exc_commit got csr,req=%b exp=10", {o_csr_update, o_trap_req});
        end
        i_trap_ack = 1'b0;
        tick();
        checks++;
        if ({o_csr_update, o_trap_req} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL exc_idle got csr,req=%b exp=00", {o_csr_update, o_trap_req});
        end
    endtask

    task automatic test_irq_vectors();
        irq_case_t   cases[7];
        exp_t        e;
        logic [23:0] exp_mip;
        int          code;
        cases[0] = '{msi: 0, mti: 1, mei: 0, loc: 8'h00, mode: 2'd1, base: 30'h80, pc: 32'h400};
        cases[1] = '{msi: 0, mti: 0, mei: 0, loc: 8'h04, mode: 2'd1, base: 30'h80, pc: 32'h404};
        cases[2] = '{msi: 1, mti: 1, mei: 1, loc: 8'hFF, mode: 2'd1, base: 30'h80, pc: 32'h408};
        cases[3] = '{msi: 1, mti: 1, mei: 0, loc: 8'h10, mode: 2'd1, base: 30'h80, pc: 32'h40C};
        cases[4] = '{msi: 0, mti: 0, mei: 0, loc: 8'h0C, mode: 2'd2, base: 30'h80, pc: 32'h410};
        cases[5] = '{msi: 0, mti: 0, mei: 0, loc: 8'h01, mode: 2'd1, base: 30'h3FFFFFFF, pc: 32'h414};
        cases[6] = '{msi: 0, mti: 1, mei: 0, loc: 8'h00, mode: 2'd3, base: 30'h123, pc: 32'h418};
        for (int k = 0; k < 7; k++) begin
            clear_inputs();
            i_mie         = 24'hFFFFFF;
            i_mstatus_mie = 1'b1;
            i_mtvec_mode  = cases[k].mode;
            i_mtvec_base  = cases[k].base;
            i_pc          = cases[k].pc;
            i_irq_msi     = cases[k].msi;
            i_irq_mti     = cases[k].mti;
            i_irq_mei     = cases[k].mei;
            i_irq_local   = cases[k].loc;
            exp_mip = {cases[k].loc, 4'b0, cases[k].mei, 3'b0, cases[k].mti, 3'b0, cases[k].msi, 3'b0};
            code = model_irq_code(exp_mip);
            sb.push_back(model_trap(1, code, cases[k].base, cases[k].mode, cases[k].pc));
            tick();
            checks++;
            if ({o_trap_req, o_mip} !== {1'b0, exp_mip}) begin
                failures++;
                $display("[TB] FAIL irq%0d_mip got req=%0b mip=%h exp req=0 mip=%h", k, o_trap_req, o_mip, exp_mip);
            end
            tick();
            checks++;
            if (o_trap_req !== 1'b1) begin
                failures++;
                $display("[TB] FAIL irq%0d_latency got=%0b exp=1", k, o_trap_req);
            end
            i_irq_msi   = 1'b0;
            i_irq_mti   = 1'b0;
            i_irq_mei   = 1'b0;
            i_irq_local = '0;
            pop_exp(e);
            checks++;
            if (o_mcause !== e.mcause) begin
                failures++;
                $display("[TB] FAIL irq%0d_mcause got=%h exp=%h", k, o_mcause, e.mcause);
            end
            checks++;
            if (o_trap_pc !== e.trap_pc) begin
                failures++;
                $display("[TB] FAIL irq%0d_trap_pc got=%h exp=%h", k, o_trap_pc, e.trap_pc);
            end
            checks++;
            if (o_mepc !== e.mepc) begin
                failures++;
                $display("[TB] FAIL irq%0d_mepc got=%h exp=%h", k, o_mepc, e.mepc);
            end
            ack_trap();
        end
    endtask

    task automatic test_exc_priority();
        logic [15:0] pats[3];
        exp_t        e;
        pats[0] = 16'h0008;
        pats[1] = 16'h00A0;
        pats[2] = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            i_mie        = 24'hFFFFFF;
            i_mtvec_mode = 2'd1;
            i_irq_mei    = 1'b1;
            tick();
            tick();
            checks++;
            if (o_trap_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL excprio%0d_masked got=%0b exp=0", k, o_trap_req);
            end
            i_mstatus_mie = 1'b1;
            i_exception   = pats[k];
            i_pc          = 32'h500 + 32'(k);
            sb.push_back(model_trap(0, model_exc_code(pats[k]), 30'h80, 2'd1, 32'h500 + 32'(k)));
            tick();
            i_exception   = '0;
            i_irq_mei     = 1'b0;
            i_mstatus_mie = 1'b0;
            pop_exp(e);
            checks++;
            if ({o_trap_req, o_mcause, o_trap_pc, o_mepc} !== {1'b1, e.mcause, e.trap_pc, e.mepc}) begin
                failures++;
                $display("[TB] FAIL excprio%0d got req=%0b cause=%h pc=%h epc=%h exp req=1 cause=%h pc=%h epc=%h",
                         k, o_trap_req, o_mcause, o_trap_pc, o_mepc, e.mcause, e.trap_pc, e.mepc);
            end
            ack_trap();
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   seen;
        int   start;
        clear_inputs();
        i_mie[11]     = 1'b1;
        i_mstatus_mie = 1'b1;
        i_irq_mei     = 1'b1;
        i_pc          = 32'h600;
        sb.push_back(model_trap(1, 11, 30'h80, 2'd0, 32'h600));
        wait_req(5, seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_req_seen got=%0b exp=1", seen);
        end
        pop_exp(e);
        for (int c = 0; c < 5; c++) begin
            i_irq_mei    = 1'b0;
            i_pc         = 32'h9000 + 32'(c);
            i_exception  = 16'h0002;
            i_mtvec_base = 30'h3F0;
            i_mtvec_mode = 2'd1;
            tick();
            checks++;
            if ({o_trap_req, o_csr_update, o_mcause, o_trap_pc, o_mepc} !== {2'b10, e.mcause, e.trap_pc, e.mepc}) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d got req=%0b csr=%0b cause=%h pc=%h epc=%h exp req=1 csr=0 cause=%h pc=%h epc=%h",
                         c, o_trap_req, o_csr_update, o_mcause, o_trap_pc, o_mepc, e.mcause, e.trap_pc, e.mepc);
            end
        end
        i_exception = '0;
        start = csr_pulses;
        ack_trap();
        tick();
        tick();
        checks++;
        if (csr_pulses - start !== 1) begin
            failures++;
            $display("[TB] FAIL hold_csr_pulses got=%0d exp=1", csr_pulses - start);
        end
    endtask

    task automatic test_enable();
        exp_t e;
        int   start;
        clear_inputs();
        start       = csr_pulses;
        i_exception = 16'h0010;
        i_pc        = 32'h800;
        sb.push_back(model_trap(0, 4, 30'h80, 2'd0, 32'h800));
        tick();
        pop_exp(e);
        checks++;
        if ({o_trap_req, o_mcause} !== {1'b1, e.mcause}) begin
            failures++;
            $display("[TB] FAIL en_req got req=%0b cause=%h exp req=1 cause=%h", o_trap_req, o_mcause, e.mcause);
        end
        i_exception = '0;
        i_enable    = 1'b0;
        #1;
        checks++;
        if (o_trap_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL en_drop got=%0b exp=0", o_trap_req);
        end
        tick();
        i_enable   = 1'b1;
        i_trap_ack = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        checks++;
        if ({o_trap_req, o_csr_update} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL en_abort got req,csr=%b exp=00", {o_trap_req, o_csr_update});
        end
        i_enable    = 1'b0;
        i_exception = 16'h0001;
        tick();
        tick();
        i_exception = '0;
        i_enable    = 1'b1;
        #1;
        checks++;
        if (o_trap_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL en_disabled_entry got=%0b exp=0", o_trap_req);
        end
        tick();
        tick();
        checks++;
        if (csr_pulses - start !== 0) begin
            failures++;
            $display("[TB] FAIL en_csr_pulses got=%0d exp=0", csr_pulses - start);
        end
    endtask

    task automatic test_reset_mid_req();
        exp_t e;
        int   start;
        clear_inputs();
        i_exception = 16'h0002;
        i_pc        = 32'h700;
        sb.push_back(model_trap(0, 1, 30'h80, 2'd0, 32'h700));
        tick();
        pop_exp(e);
        checks++;
        if ({o_trap_req, o_mepc} !== {1'b1, e.mepc}) begin
            failures++;
            $display("[TB] FAIL rst_req got req=%0b epc=%h exp req=1 epc=%h", o_trap_req, o_mepc, e.mepc);
        end
        i_exception = '0;
        i_trap_ack  = 1'b1;
        i_rst_n     = 1'b0;
        start       = csr_pulses;
        #2;
        checks++;
        if ({o_trap_req, o_csr_update, o_trap_pc, o_mcause, o_mepc, o_mip} !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs got req=%0b csr=%0b pc=%h cause=%h epc=%h mip=%h exp=all zero",
                     o_trap_req, o_csr_update, o_trap_pc, o_mcause, o_mepc, o_mip);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        i_trap_ack = 1'b0;
        checks++;
        if ({csr_pulses - start, o_trap_req} !== {32'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_abandon got pulses=%0d req=%0b exp pulses=0 req=0", csr_pulses - start, o_trap_req);
        end
    endtask

    task automatic test_mie_masked();
        bit seen;
        clear_inputs();
        i_mie[11]     = 1'b1;
        i_mstatus_mie = 1'b0;
        i_irq_mei     = 1'b1;
        wait_req(4, seen);
        checks++;
        if ({seen, o_mip[11]} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mie_masked got req_seen=%0b mip11=%0b exp req_seen=0 mip11=1", seen, o_mip[11]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen;
        clear_inputs();
        i_exception = 16'h0002;
        i_pc        = 32'h10;
        sb.push_back(model_trap(0, 1, 30'h80, 2'd0, 32'h10));
        tick();
        pop_exp(e);
        checks++;
        if ({o_trap_req, o_mepc} !== {1'b1, e.mepc}) begin
            failures++;
            $display("[TB] FAIL b2b_first got req=%0b epc=%h exp req=1 epc=%h", o_trap_req, o_mepc, e.mepc);
        end
        i_pc = 32'h20;
        sb.push_back(model_trap(0, 1, 30'h80, 2'd0, 32'h20));
        i_trap_ack = 1'b1;
        tick();
        i_trap_ack = 1'b0;
        wait_req(4, seen);
        pop_exp(e);
        checks++;
        if ({seen, o_mcause, o_mepc} !== {1'b1, e.mcause, e.mepc}) begin
            failures++;
            $display("[TB] FAIL b2b_second got seen=%0b cause=%h epc=%h exp seen=1 cause=%h epc=%h",
                     seen, o_mcause, o_mepc, e.mcause, e.mepc);
        end
        i_exception = '0;
        ack_trap();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq_vectors();
        test_exc_priority();
        test_hold();
        test_enable();
        test_reset_mid_req();
        test_mie_masked();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
